// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester handshakes and the Data_Mem bus for dmem_arbiter.
//   slave  : arbiter side (takes requests and read_data; drives acks, rdata,
//            the memory bus and busy)
//   master : environment side (requesters plus Data_Mem)
//   Signals:
//     p0_req/p0_we/p0_addr/p0_wdata  port 0 request, held until p0_ack
//     p0_ack/p0_rdata                port 0 completion pulse and read data
//     p1_*                           same for port 1
//     memRead/memWrite/address/write_data   to Data_Mem
//     read_data                      from Data_Mem
//     busy                           arbiter not idle
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  read_data,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output memRead, memWrite, address, write_data,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output read_data,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  memRead, memWrite, address, write_data,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported Data_Mem between port 0 (CPU MEM stage) and
//   port 1 (DMA/debug loader). Each transaction runs IDLE -> ACCESS -> DONE:
//   request sampled in IDLE, one memory cycle in ACCESS, one-cycle ack in DONE.
//   All outputs are registered; no combinational path from requests to the bus.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  dmem_arbiter_if.slave (requester handshakes, Data_Mem bus, busy)
//   Build option:
//     DMEM_ARB_ROUND_ROBIN_EN  simultaneous requests go to the port that did
//                              not win last; otherwise port 0 wins ties.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              win_id;

  logic              any_req;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (bus.p0_req && bus.p1_req) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = bus.p1_req;
    end
`else
    grant_id = ~bus.p0_req & bus.p1_req;
`endif
    sel_we    = grant_id ? bus.p1_we    : bus.p0_we;
    sel_addr  = grant_id ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = grant_id ? bus.p1_wdata : bus.p0_wdata;
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Fixed priority keeps last_grant tracked for visibility only.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      win_id         <= 1'b0;
      bus.memRead    <= 1'b0;
      bus.memWrite   <= 1'b0;
      bus.address    <= '0;
      bus.write_data <= '0;
      bus.p0_ack     <= 1'b0;
      bus.p1_ack     <= 1'b0;
      bus.p0_rdata   <= '0;
      bus.p1_rdata   <= '0;
      bus.busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
          if (any_req) begin
            // Bus outputs are loaded here so they are valid throughout ACCESS.
            win_id         <= grant_id;
            last_grant     <= grant_id;
            bus.memRead    <= ~sel_we;
            bus.memWrite   <= sel_we;
            bus.address    <= sel_addr;
            bus.write_data <= sel_wdata;
            bus.busy       <= 1'b1;
            state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus.memRead  <= 1'b0;
          bus.memWrite <= 1'b0;
          if (bus.memRead) begin
            if (win_id) bus.p1_rdata <= bus.read_data;
            else        bus.p0_rdata <= bus.read_data;
          end
          if (win_id) bus.p1_ack <= 1'b1;
          else        bus.p0_ack <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          bus.memRead  <= 1'b0;
          bus.memWrite <= 1'b0;
          bus.p0_ack   <= 1'b0;
          bus.p1_ack   <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed and randomized bench for dmem_arbiter with a behavioural Data_Mem
//   and a transaction-level reference model (memory image, last winner,
//   per-port read data).
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data_Mem: combinational read while memRead, write on rising edge.
  logic [15:0] mem [0:255];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 37 + 5);
    end else if (bus.memWrite) begin
      mem[bus.address[7:0]] <= bus.write_data;
    end
  end
  assign bus.read_data = bus.memRead ? mem[bus.address[7:0]] : '0;

  // Reference model state.
  logic [15:0] ref_mem [0:255];
  int          ref_last;
  logic [15:0] ref_rdata [2];

  int vectors    = 0;
  int miscompares = 0;

  bit          pend [2];
  bit          op_we [2];
  logic [15:0] op_addr [2];
  logic [15:0] op_wd [2];
  bit          hold_reqs;
  bit          mutate_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p);
    if (p == 0) begin
      bus.p0_req = pend[0]; bus.p0_we = op_we[0];
      bus.p0_addr = op_addr[0]; bus.p0_wdata = op_wd[0];
    end else begin
      bus.p1_req = pend[1]; bus.p1_we = op_we[1];
      bus.p1_addr = op_addr[1]; bus.p1_wdata = op_wd[1];
    end
  endtask

  task automatic set_op(input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
    op_we[p] = we; op_addr[p] = a; op_wd[p] = d; pend[p] = 1'b1;
    drive_port(p);
  endtask

  task automatic model_reset();
    ref_last = 1;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
  endtask

  function automatic int pick_winner();
    if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return (ref_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return pend[0] ? 0 : 1;
  endfunction

  // Entered at a negedge in IDLE with requests already driven.
  task automatic serve_one();
    int w;
    int o;
    w = pick_winner();
    o = 1 - w;
    @(negedge clk);
    check("access_busy", bus.busy, 1);
    check("access_memRead", bus.memRead, !op_we[w]);
    check("access_memWrite", bus.memWrite, op_we[w]);
    check("access_address", bus.address, op_addr[w]);
    if (op_we[w]) check("access_write_data", bus.write_data, op_wd[w]);
    check("access_no_ack", {bus.p0_ack, bus.p1_ack}, 0);
    if (op_we[w]) ref_mem[op_addr[w][7:0]] = op_wd[w];
    else          ref_rdata[w] = ref_mem[op_addr[w][7:0]];
    ref_last = w;
    if (mutate_addr) begin
      op_addr[w] = op_addr[w] + 16'd1;
      drive_port(w);
    end
    @(negedge clk);
    check("done_ack_winner", (w == 0) ? bus.p0_ack : bus.p1_ack, 1);
    check("done_ack_loser", (w == 0) ? bus.p1_ack : bus.p0_ack, 0);
    check("done_rdata_winner", (w == 0) ? bus.p0_rdata : bus.p1_rdata, ref_rdata[w]);
    check("done_rdata_loser", (w == 0) ? bus.p1_rdata : bus.p0_rdata, ref_rdata[o]);
    check("done_mem_idle", {bus.memRead, bus.memWrite}, 0);
    if (!hold_reqs) begin
      pend[w] = 1'b0;
      drive_port(w);
    end
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_no_ack", {bus.p0_ack, bus.p1_ack}, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((pend[0] || pend[1]) && guard < 8) begin
      serve_one();
      guard++;
    end
    check("drain_bounded", {31'd0, pend[0] | pend[1]}, 0);
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0;
    op_we[0] = 0; op_we[1] = 0;
    op_addr[0] = '0; op_addr[1] = '0;
    op_wd[0] = '0; op_wd[1] = '0;
    hold_reqs = 0; mutate_addr = 0;
    drive_port(0); drive_port(1);
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_ctl", {bus.memRead, bus.memWrite}, 0);
    check("rst_address", bus.address, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_acks", {bus.p0_ack, bus.p1_ack}, 0);
    check("rst_p0_rdata", bus.p0_rdata, 0);
    check("rst_p1_rdata", bus.p1_rdata, 0);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("idle_after_rst_busy", bus.busy, 0);
      check("idle_after_rst_mem", {bus.memRead, bus.memWrite}, 0);
    end

    // Port 0 write then read back.
    set_op(0, 1'b1, 16'd20, 16'd15);
    serve_one();
    set_op(0, 1'b0, 16'd20, 16'd0);
    serve_one();
    check("p0_readback_20", bus.p0_rdata, 16'd15);

    // Port 1 read of preloaded location 0.
    set_op(1, 1'b0, 16'd0, 16'd0);
    serve_one();
    check("p1_read_0", bus.p1_rdata, 16'd5);

    // Both ports requesting and held for four transactions.
    hold_reqs = 1'b1;
    set_op(0, 1'b0, 16'd3, 16'd0);
    set_op(1, 1'b0, 16'd4, 16'd0);
    repeat (4) serve_one();
    hold_reqs = 1'b0;
    pend[0] = 1'b0;
    drive_port(0);
    drain();

    // Reset during a write's ACCESS cycle suppresses the write and the ack.
    set_op(0, 1'b1, 16'd7, 16'hAAAA);
    @(negedge clk);
    check("abort_write_active", bus.memWrite, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_memWrite_async", bus.memWrite, 0);
    check("abort_busy_async", bus.busy, 0);
    pend[0] = 1'b0;
    drive_port(0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack", {bus.p0_ack, bus.p1_ack}, 0);
      check("abort_rdata_cleared", bus.p0_rdata, 0);
    end
    set_op(0, 1'b0, 16'd7, 16'd0);
    serve_one();
    check("abort_old_contents", bus.p0_rdata, 16'(7 * 37 + 5));

    // Address change after grant is ignored.
    mutate_addr = 1'b1;
    set_op(0, 1'b0, 16'd30, 16'd0);
    serve_one();
    mutate_addr = 1'b0;
    pend[0] = 1'b0;
    drive_port(0);
    check("latched_addr_30", bus.p0_rdata, 16'(30 * 37 + 5));

    // Randomized mix of single and contending requests.
    repeat (30) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode != 1) set_op(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
      if (mode != 0) set_op(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
